decode_stage: RTL and testbench

- Instruction Decode (ID) stage of the 32-bit pipelined MIPS core; sits between the IF/ID and ID/EX pipeline registers.
- Splits the 32-bit instruction into its fields, reads two operands from a 32x32 register file, and sign-extends the 16-bit immediate.
- Accepts the write-back port from the WB stage.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/register_file.sv | 58 +++++
 rtl/decode_stage.sv | 55 +++++
 tb/tb_decode_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS datapath: widths, opcodes and instruction field positions.
package mips_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  // Primary opcodes used by the core
  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2B;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] ADDI   = 6'h08;

  // Instruction field bit positions (MSB / LSB)
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_MSB     = 15;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// asynchronous active-low clear, r0 hard-wired to zero, write-before-read bypass.
module register_file
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W    = mips_pkg::DATA_W,
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_addr_1,
  input  logic [ADDR_W-1:0] read_addr_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data
);

  logic [DATA_W-1:0] regs_q [REG_COUNT];
  logic              write_ok;

  // Writes to r0 are dropped so it stays zero; the read path also forces it to zero.
  assign write_ok = write_en && (write_addr != '0);

  // Register array: async clear, write on rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (write_ok) begin
      regs_q[write_addr] <= write_data;
    end
  end

  // Read port 1 with WB bypass; bypass is suppressed in reset since the write is ignored then
  always_comb begin
    read_data_1 = regs_q[read_addr_1];
    if (read_addr_1 == '0) begin
      read_data_1 = '0;
    end else if (rst_n && write_ok && (write_addr == read_addr_1)) begin
      read_data_1 = write_data;
    end
  end

  // Read port 2 with WB bypass, independent of port 1
  always_comb begin
    read_data_2 = regs_q[read_addr_2];
    if (read_addr_2 == '0) begin
      read_data_2 = '0;
    end else if (rst_n && write_ok && (write_addr == read_addr_2)) begin
      read_data_2 = write_data;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS instruction decode stage: field slicing, sign extension and register file access.
module decode_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W    = mips_pkg::DATA_W,
  parameter int unsigned REG_COUNT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       Instruction,
  input  logic              RegWrite,
  input  logic [4:0]        Write_Register,
  input  logic [DATA_W-1:0] Write_Data,
  output logic [5:0]        Opcode,
  output logic [DATA_W-1:0] Read_Data_1,
  output logic [DATA_W-1:0] Read_Data_2,
  output logic [DATA_W-1:0] Sign_Extended_Immediate,
  output logic [4:0]        rt,
  output logic [4:0]        rd
);

  logic [4:0]  rs;
  logic [15:0] imm;

  // Field slicing, purely combinational
  always_comb begin
    Opcode = Instruction[OPCODE_MSB:OPCODE_LSB];
    rs     = Instruction[RS_MSB:RS_LSB];
    rt     = Instruction[RT_MSB:RT_LSB];
    rd     = Instruction[RD_MSB:RD_LSB];
    imm    = Instruction[IMM_MSB:IMM_LSB];
  end

  // Sign-extend the 16-bit immediate to the datapath width
  always_comb begin
    Sign_Extended_Immediate = {{(DATA_W - 16){imm[15]}}, imm};
  end

  register_file #(
    .DATA_W    (DATA_W),
    .REG_COUNT (REG_COUNT),
    .ADDR_W    (5)
  ) u_register_file (
    .clk         (clk),
    .rst_n       (rst_n),
    .read_addr_1 (rs),
    .read_addr_2 (rt),
    .read_data_1 (Read_Data_1),
    .read_data_2 (Read_Data_2),
    .write_en    (RegWrite),
    .write_addr  (Write_Register),
    .write_data  (Write_Data)
  );

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] Instruction;
  logic        RegWrite;
  logic [4:0]  Write_Register;
  logic [31:0] Write_Data;
  logic [5:0]  Opcode;
  logic [31:0] Read_Data_1;
  logic [31:0] Read_Data_2;
  logic [31:0] Sign_Extended_Immediate;
  logic [4:0]  rt;
  logic [4:0]  rd;

  int errors = 0;
  int checks = 0;

  decode_stage dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .Instruction             (Instruction),
    .RegWrite                (RegWrite),
    .Write_Register          (Write_Register),
    .Write_Data              (Write_Data),
    .Opcode                  (Opcode),
    .Read_Data_1             (Read_Data_1),
    .Read_Data_2             (Read_Data_2),
    .Sign_Extended_Immediate (Sign_Extended_Immediate),
    .rt                      (rt),
    .rd                      (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a write for one rising edge, then drop RegWrite
  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    RegWrite       = 1'b1;
    Write_Register = addr;
    Write_Data     = data;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
  endtask

  initial begin
    logic [31:0] ins;
    rst_n          = 1'b0;
    Instruction    = 32'h0;
    RegWrite       = 1'b0;
    Write_Register = 5'd0;
    Write_Data     = 32'h0;

    // 1. Reset state
    #3;
    check("rst_rd1", Read_Data_1, 32'h0);
    check("rst_rd2", Read_Data_2, 32'h0);
    check("rst_opcode", {26'h0, Opcode}, 32'h0);
    check("rst_sext", Sign_Extended_Immediate, 32'h0);
    #9 rst_n = 1'b1;  // released between edges
    #1;
    for (int i = 0; i < 32; i++) begin
      ins = {6'h0, 5'(i), 5'(i), 16'h0};
      Instruction = ins;
      #1;
      check($sformatf("init_rd1_r%0d", i), Read_Data_1, 32'h0);
      check($sformatf("init_rd2_r%0d", i), Read_Data_2, 32'h0);
    end

    // 2. Write then read back via add $10,$8,$9
    @(negedge clk);
    wb_write(5'd8, 32'h12345678);
    wb_write(5'd9, 32'hCAFEF00D);
    Instruction = 32'h01095020;
    #1;
    check("add_rd1", Read_Data_1, 32'h12345678);
    check("add_rd2", Read_Data_2, 32'hCAFEF00D);
    check("add_opcode", {26'h0, Opcode}, 32'h0);
    check("add_rt", {27'h0, rt}, 32'd9);
    check("add_rd", {27'h0, rd}, 32'd10);

    // 3. Sign extension
    Instruction = 32'h2128FFFC;
    #1;
    check("addi_sext", Sign_Extended_Immediate, 32'hFFFFFFFC);
    check("addi_opcode", {26'h0, Opcode}, 32'h08);
    check("addi_rt", {27'h0, rt}, 32'd8);
    check("addi_rs_read", Read_Data_1, 32'hCAFEF00D);
    Instruction = 32'h8D2A7FFF;
    #1;
    check("lw_sext", Sign_Extended_Immediate, 32'h00007FFF);
    check("lw_opcode", {26'h0, Opcode}, 32'h23);
    check("lw_rt", {27'h0, rt}, 32'd10);

    // 4. Register 0 stays zero, no bypass for r0
    @(negedge clk);
    Instruction    = 32'h00000000;
    RegWrite       = 1'b1;
    Write_Register = 5'd0;
    Write_Data     = 32'hFFFFFFFF;
    #1;
    check("r0_wcycle_rd1", Read_Data_1, 32'h0);
    check("r0_wcycle_rd2", Read_Data_2, 32'h0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    #1;
    check("r0_after_rd1", Read_Data_1, 32'h0);
    check("r0_after_rd2", Read_Data_2, 32'h0);

    // 5. Write-before-read bypass
    @(negedge clk);
    wb_write(5'd8, 32'h11111111);
    Instruction = 32'h01080000;  // rs=8, rt=8
    #1;
    check("pre_byp_rd1", Read_Data_1, 32'h11111111);
    RegWrite       = 1'b1;
    Write_Register = 5'd8;
    Write_Data     = 32'h22222222;
    #1;
    check("byp_rd1", Read_Data_1, 32'h22222222);
    check("byp_rd2", Read_Data_2, 32'h22222222);
    Instruction = 32'h01090000;  // rs=8, rt=9: only port 1 bypasses
    #1;
    check("byp_only_rd1", Read_Data_1, 32'h22222222);
    check("byp_not_rd2", Read_Data_2, 32'hCAFEF00D);
    Instruction = 32'h01080000;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    #1;
    check("post_byp_rd1", Read_Data_1, 32'h22222222);
    check("post_byp_rd2", Read_Data_2, 32'h22222222);

    // 6. Asynchronous reset mid-operation
    @(negedge clk);
    wb_write(5'd5, 32'hA5A5A5A5);
    Instruction = 32'h00A50000;  // rs=5, rt=5
    #1;
    check("r5_written", Read_Data_1, 32'hA5A5A5A5);
    rst_n = 1'b0;  // between edges
    #1;
    check("async_clr_rd1", Read_Data_1, 32'h0);
    check("async_clr_rd2", Read_Data_2, 32'h0);
    Instruction = 32'h01090000;
    #1;
    check("async_clr_r8", Read_Data_1, 32'h0);
    check("async_clr_r9", Read_Data_2, 32'h0);
    Instruction = 32'h00A50000;
    RegWrite       = 1'b1;
    Write_Register = 5'd5;
    Write_Data     = 32'hDEADBEEF;
    #1;
    check("rst_write_nobyp", Read_Data_1, 32'h0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    #1;
    check("rst_write_ignored", Read_Data_1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_r5", Read_Data_2, 32'h0);
    wb_write(5'd5, 32'h0BADF00D);
    #1;
    check("post_rst_write", Read_Data_1, 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
